pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and forwarding controller for the pipelined ARM datapath, covering the IF, ID, EX, MEM and WB stages.
- Keeps its own shadow pipeline of in-flight register-write tags covering EX, MEM and WB.
- From these tags it drives the stall, flush and forward-select signals for the IF/ID/EX/MEM pipeline registers.
- Parametrised in register-file size, source-operand count (Rn, Rm, Rs) and load latency. Also handles PC-write hazards.

Parameters:
- NREGS, 16: architectural register count.
- RA_W, $clog2(NREGS): register-address width.
- NSRC, 3: source operands compared per instruction (Rn, Rm, Rs).
- LOAD_LAT, 1: cycles after EX before load data is forwardable. Legal values are 1 and 2; any other value is an elaboration error.
- PC_REG, 15: index of the PC register.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NSRC*RA_W  ID source register addresses, slot i at [i*RA_W +: RA_W].
- id_src_used  in  NSRC  per-slot "operand actually read".
- id_dest  in  RA_W  ID destination register.
- id_regwrite  in  1  ID instruction writes id_dest.
- id_memtoreg  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch or PC-redirect resolved taken in EX this cycle.
- stall_f  out  1  hold PC register.
- stall_d  out  1  hold IF/ID register.
- flush_d  out  1  clear IF/ID register.
- flush_e  out  1  clear ID/EX register (insert bubble).
- fwd_sel  out  2*NSRC  per EX operand: 00 regfile, 01 WB result, 10 MEM ALU result.
- perf_stall_cnt  out  32  stall-cycle counter (optional feature).
- perf_flush_cnt  out  32  flush-event counter (optional feature).

Behaviour:
- Tags: ex_tag, mem_tag and wb_tag, each {valid, we, is_load, dest}, plus ex_src/ex_used for forwarding.
  - Every non-reset cycle: wb_tag <= mem_tag, mem_tag <= ex_tag.
  - ex_tag <= ID fields when id_valid && !flush_e && !stall_d; otherwise ex_tag <= bubble (valid=0).
- Reset (reset==0 at clk edge): all tags invalid and counters cleared.
  - While reset is low: flush_d = flush_e = 1, stall_f = stall_d = 0, fwd_sel = 0.
  - Reset mid-stall discards the stall. First post-reset cycle outputs all 0.
- Forwarding is combinational, per EX slot i.
  - 10 if mem_tag.valid && we && !is_load && dest==ex_src[i] && ex_used[i] && ex_src[i]!=PC_REG.
  - Else 01 if the same test passes on wb_tag, with loads allowed.
  - Else 00. MEM has priority over WB.
  - PC_REG is never forwarded; the datapath supplies PC+8.
- Load-use hazard: lu = id_valid && some used ID source matches a valid, writing, is_load tag in EX.
  - When LOAD_LAT==2, a matching tag in MEM also counts.
  - On lu: stall_f = stall_d = 1 and flush_e = 1 (one bubble per cycle). The stall lasts exactly LOAD_LAT cycles.
- PC-write hazard: pcw = any valid tag in ID/EX/MEM with we && dest==PC_REG.
  - On pcw: stall_f = 1 and flush_d = 1, until the write reaches WB.
- Branch: ex_branch_taken forces flush_d = flush_e = 1 and stall_f = stall_d = 0. It overrides both lu and pcw in the same cycle.
- A source register matching two pending loads (EX and MEM) counts as a single stall event.
- All outputs are combinational from tags and ID inputs. Tags update with 1-cycle latency.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with stall_d=1.
  - perf_flush_cnt increments on every cycle with ex_branch_taken=1.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - stage_tag_t packed struct {valid, we, is_load, dest}.
  - PC_REG_DEFAULT constant.
- Sub-module hazard_fwd_cmp is instantiated NSRC times. Given one source and the MEM and WB tags, it returns fwd_sel_t.

Test Plan:
- ADD R1 then ADD R2,R1,R3 back-to-back -> cycle 2 fwd_sel slot0 = 10; with one NOP between -> 01; no stall.
- LDR R4 then ADD R5,R4,R6 with LOAD_LAT=1 -> stall_f = stall_d = flush_e = 1 for exactly 1 cycle, then fwd_sel slot0 = 01. With LOAD_LAT=2 -> 2 stall cycles.
- LDR R4 followed by a taken branch in EX during the stall -> flush_d = flush_e = 1, stall_f = 0 that cycle.
- MOV PC,R0 (dest 15) in ID -> stall_f = flush_d = 1 for 3 cycles, released when the tag reaches WB.
- Read of R15 with a pending R15 write in MEM -> fwd_sel = 00.
- reset=0 asserted during an active load-use stall -> next cycle all tags invalid; after release all outputs 0. Under HAZARD_PERF_CNT_EN, 5 stalls then 2 branches -> counters read 5 and 2.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Tag destinations are stored zero-extended to RA_W_MAX bits so one
// struct type serves every register-file size up to 256 entries.
package hazard_pkg;

  localparam int unsigned PC_REG_DEFAULT = 15;
  localparam int unsigned RA_W_MAX       = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic                is_load;
    logic [RA_W_MAX-1:0] dest;
  } stage_tag_t;

  // True when the tag holds a live instruction writing register r.
  function automatic logic tag_writes(input stage_tag_t t, input logic [RA_W_MAX-1:0] r);
    return t.valid && t.we && (t.dest == r);
  endfunction

  // True when the tag holds a live load whose destination is register r.
  function automatic logic tag_loads(input stage_tag_t t, input logic [RA_W_MAX-1:0] r);
    return tag_writes(t, r) && t.is_load;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request / hazard-control response bundle.
// master: the pipeline datapath; slave: the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned NSRC = 3,
  parameter int unsigned RA_W = 4
);
  logic                 id_valid;
  logic [NSRC*RA_W-1:0] id_src;
  logic [NSRC-1:0]      id_src_used;
  logic [RA_W-1:0]      id_dest;
  logic                 id_regwrite;
  logic                 id_memtoreg;
  logic                 ex_branch_taken;
  logic                 stall_f;
  logic                 stall_d;
  logic                 flush_d;
  logic                 flush_e;
  logic [2*NSRC-1:0]    fwd_sel;

  modport master (
    output id_valid, id_src, id_src_used, id_dest, id_regwrite, id_memtoreg,
           ex_branch_taken,
    input  stall_f, stall_d, flush_d, flush_e, fwd_sel
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_dest, id_regwrite, id_memtoreg,
           ex_branch_taken,
    output stall_f, stall_d, flush_d, flush_e, fwd_sel
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_cmp.sv
// Forward-source selection for one EX operand. MEM beats WB; loads in
// MEM are not forwardable yet; the PC is never forwarded (datapath gives PC+8).
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned PC_REG = PC_REG_DEFAULT
) (
  input  logic [RA_W_MAX-1:0] src,
  input  logic                used,
  input  stage_tag_t          mem_tag,
  input  stage_tag_t          wb_tag,
  output fwd_sel_t            sel
);
  localparam logic [RA_W_MAX-1:0] PC_ADDR = RA_W_MAX'(PC_REG);

  logic mem_hit_s;
  logic wb_hit_s;
  logic unused_wb_load_s;

  // WB forwards loads and ALU results alike, so its load flag is not needed.
  assign unused_wb_load_s = wb_tag.is_load;

  // Priority select of the youngest forwardable producer.
  always_comb begin
    mem_hit_s = used && (src != PC_ADDR) && tag_writes(mem_tag, src) && !mem_tag.is_load;
    wb_hit_s  = used && (src != PC_ADDR) && tag_writes(wb_tag, src);
    if (mem_hit_s) begin
      sel = FWD_MEM;
    end else if (wb_hit_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage ARM pipeline.
// Tracks EX/MEM/WB write tags and derives stall, flush and forward selects.
// Optional stall/flush performance counters: define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NREGS    = 16,
  parameter int unsigned RA_W     = $clog2(NREGS),
  parameter int unsigned NSRC     = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned PC_REG   = PC_REG_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
);
  localparam logic [RA_W_MAX-1:0] PC_ADDR = RA_W_MAX'(PC_REG);

  if ((LOAD_LAT != 1) && (LOAD_LAT != 2)) begin : g_bad_load_lat
    $error("pipe_hazard_ctrl: LOAD_LAT must be 1 or 2");
  end
  if ((RA_W > RA_W_MAX) || (NREGS > (1 << RA_W))) begin : g_bad_regs
    $error("pipe_hazard_ctrl: register file size out of range");
  end

  stage_tag_t           ex_tag_q, ex_tag_d;
  stage_tag_t           mem_tag_q, mem_tag_d;
  stage_tag_t           wb_tag_q, wb_tag_d;
  logic [NSRC*RA_W-1:0] ex_src_q, ex_src_d;
  logic [NSRC-1:0]      ex_used_q, ex_used_d;

  logic                 lu_s;
  logic                 pcw_s;
  logic                 stall_f_s, stall_d_s, flush_d_s, flush_e_s;
  logic [RA_W_MAX-1:0]  id_src_w_s [NSRC];
  logic [RA_W_MAX-1:0]  ex_src_w_s [NSRC];
  fwd_sel_t             fwd_s      [NSRC];
  logic [2*NSRC-1:0]    fwd_sel_s;

  // Widen per-slot source addresses to the tag destination width.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      id_src_w_s[i] = RA_W_MAX'(hz.id_src[i*RA_W +: RA_W]);
      ex_src_w_s[i] = RA_W_MAX'(ex_src_q[i*RA_W +: RA_W]);
    end
  end

  // Load-use and PC-write hazard detection; two pending loads on one source still give one stall.
  always_comb begin
    lu_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      lu_s = lu_s | (hz.id_src_used[i] &&
                     (tag_loads(ex_tag_q, id_src_w_s[i]) ||
                      ((LOAD_LAT == 2) && tag_loads(mem_tag_q, id_src_w_s[i]))));
    end
    lu_s  = lu_s && hz.id_valid;
    pcw_s = (hz.id_valid && hz.id_regwrite && (RA_W_MAX'(hz.id_dest) == PC_ADDR)) ||
            tag_writes(ex_tag_q, PC_ADDR) || tag_writes(mem_tag_q, PC_ADDR);
  end

  // Control outputs: reset and taken branch override both hazards.
  always_comb begin
    if (!reset || hz.ex_branch_taken) begin
      stall_f_s = 1'b0;
      stall_d_s = 1'b0;
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      stall_f_s = lu_s | pcw_s;
      stall_d_s = lu_s;
      flush_d_s = pcw_s;
      flush_e_s = lu_s;
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_fwd
    hazard_fwd_cmp #(.PC_REG(PC_REG)) u_cmp (
      .src     (ex_src_w_s[g]),
      .used    (ex_used_q[g]),
      .mem_tag (mem_tag_q),
      .wb_tag  (wb_tag_q),
      .sel     (fwd_s[g])
    );
  end

  // Pack per-slot forward selects; forced to regfile while in reset.
  always_comb begin
    fwd_sel_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_sel_s[2*i +: 2] = reset ? fwd_s[i] : FWD_RF;
    end
  end

  assign hz.stall_f = stall_f_s;
  assign hz.stall_d = stall_d_s;
  assign hz.flush_d = flush_d_s;
  assign hz.flush_e = flush_e_s;
  assign hz.fwd_sel = fwd_sel_s;

  // Shadow pipeline advance: ID enters EX unless stalled or bubbled.
  always_comb begin
    mem_tag_d = ex_tag_q;
    wb_tag_d  = mem_tag_q;
    if (hz.id_valid && !flush_e_s && !stall_d_s) begin
      ex_tag_d.valid   = 1'b1;
      ex_tag_d.we      = hz.id_regwrite;
      ex_tag_d.is_load = hz.id_memtoreg;
      ex_tag_d.dest    = RA_W_MAX'(hz.id_dest);
      ex_src_d         = hz.id_src;
      ex_used_d        = hz.id_src_used;
    end else begin
      ex_tag_d  = '0;
      ex_src_d  = '0;
      ex_used_d = '0;
    end
  end

  // Tag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_tag_q  <= '0;
      mem_tag_q <= '0;
      wb_tag_q  <= '0;
      ex_src_q  <= '0;
      ex_used_q <= '0;
    end else begin
      ex_tag_q  <= ex_tag_d;
      mem_tag_q <= mem_tag_d;
      wb_tag_q  <= wb_tag_d;
      ex_src_q  <= ex_src_d;
      ex_used_q <= ex_used_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  // Free-running wrap-around event counters.
  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, stall_d_s};
    perf_flush_cnt_d = perf_flush_cnt_q + {31'd0, hz.ex_branch_taken};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cnt_q <= 32'd0;
      perf_flush_cnt_q <= 32'd0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_LAT 1 and 2) share one
// stimulus stream and are compared every cycle against a stage-list model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        ld;
    logic [3:0]  dest;
    logic [11:0] src;
    logic [2:0]  used;
  } instr_t;

  logic clk;
  logic in_rst;
  logic in_valid, in_we, in_ld, in_br;
  logic [11:0] in_src;
  logic [2:0]  in_used;
  logic [3:0]  in_dest;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // model state: [dut][stage] with stage 0=EX 1=MEM 2=WB
  instr_t pipe [2][3];
  logic [31:0] m_stall [2];
  logic [31:0] m_flush [2];
  logic e_sf [2], e_sd [2], e_fd [2], e_fe [2];
  logic [5:0] e_fwd [2];

  pipe_hazard_ctrl_if #(.NSRC(3), .RA_W(4)) if1 ();
  pipe_hazard_ctrl_if #(.NSRC(3), .RA_W(4)) if2 ();
  logic [31:0] ps1, pf1, ps2, pf2;

  assign if1.id_valid = in_valid;        assign if2.id_valid = in_valid;
  assign if1.id_src = in_src;            assign if2.id_src = in_src;
  assign if1.id_src_used = in_used;      assign if2.id_src_used = in_used;
  assign if1.id_dest = in_dest;          assign if2.id_dest = in_dest;
  assign if1.id_regwrite = in_we;        assign if2.id_regwrite = in_we;
  assign if1.id_memtoreg = in_ld;        assign if2.id_memtoreg = in_ld;
  assign if1.ex_branch_taken = in_br;    assign if2.ex_branch_taken = in_br;

  pipe_hazard_ctrl #(.NREGS(16), .NSRC(3), .LOAD_LAT(1), .PC_REG(15)) u_dut1 (
    .clk(clk), .reset(in_rst), .hz(if1), .perf_stall_cnt(ps1), .perf_flush_cnt(pf1));
  pipe_hazard_ctrl #(.NREGS(16), .NSRC(3), .LOAD_LAT(2), .PC_REG(15)) u_dut2 (
    .clk(clk), .reset(in_rst), .hz(if2), .perf_stall_cnt(ps2), .perf_flush_cnt(pf2));

  logic o_sf [2], o_sd [2], o_fd [2], o_fe [2];
  logic [5:0] o_fwd [2];
  logic [31:0] o_ps [2], o_pf [2];
  assign o_sf[0] = if1.stall_f;  assign o_sf[1] = if2.stall_f;
  assign o_sd[0] = if1.stall_d;  assign o_sd[1] = if2.stall_d;
  assign o_fd[0] = if1.flush_d;  assign o_fd[1] = if2.flush_d;
  assign o_fe[0] = if1.flush_e;  assign o_fe[1] = if2.flush_e;
  assign o_fwd[0] = if1.fwd_sel; assign o_fwd[1] = if2.fwd_sel;
  assign o_ps[0] = ps1; assign o_ps[1] = ps2;
  assign o_pf[0] = pf1; assign o_pf[1] = pf2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rules applied to the current ID inputs and the in-flight instruction list.
  task automatic compute_expect(input int d);
    instr_t ex, mem, wb;
    logic lu, pcw;
    logic [3:0] r;
    logic [1:0] f;
    ex = pipe[d][0]; mem = pipe[d][1]; wb = pipe[d][2];
    lu = 1'b0;
    for (int s = 0; s < 3; s++) begin
      r = in_src[s*4 +: 4];
      if (in_valid && in_used[s]) begin
        if (ex.valid && ex.we && ex.ld && ex.dest == r) lu = 1'b1;
        if (d == 1 && mem.valid && mem.we && mem.ld && mem.dest == r) lu = 1'b1;
      end
    end
    pcw = (in_valid && in_we && in_dest == 4'd15) ||
          (ex.valid && ex.we && ex.dest == 4'd15) ||
          (mem.valid && mem.we && mem.dest == 4'd15);
    if (!in_rst || in_br) begin
      e_sf[d] = 1'b0; e_sd[d] = 1'b0; e_fd[d] = 1'b1; e_fe[d] = 1'b1;
    end else begin
      e_sf[d] = lu | pcw; e_sd[d] = lu; e_fd[d] = pcw; e_fe[d] = lu;
    end
    e_fwd[d] = 6'd0;
    if (in_rst && ex.valid) begin
      for (int s = 0; s < 3; s++) begin
        r = ex.src[s*4 +: 4];
        f = 2'b00;
        if (ex.used[s] && r != 4'd15) begin
          if (mem.valid && mem.we && !mem.ld && mem.dest == r) f = 2'b10;
          else if (wb.valid && wb.we && wb.dest == r) f = 2'b01;
        end
        e_fwd[d][2*s +: 2] = f;
      end
    end
  endtask

  // Let the combinational outputs settle mid-cycle and compare both DUTs.
  task automatic settle();
    logic [31:0] eps, epf;
    #2;
    for (int d = 0; d < 2; d++) begin
      compute_expect(d);
`ifdef HAZARD_PERF_CNT_EN
      eps = m_stall[d]; epf = m_flush[d];
`else
      eps = 32'd0; epf = 32'd0;
`endif
      check($sformatf("d%0d_stall_f", d + 1), 32'(o_sf[d]), 32'(e_sf[d]));
      check($sformatf("d%0d_stall_d", d + 1), 32'(o_sd[d]), 32'(e_sd[d]));
      check($sformatf("d%0d_flush_d", d + 1), 32'(o_fd[d]), 32'(e_fd[d]));
      check($sformatf("d%0d_flush_e", d + 1), 32'(o_fe[d]), 32'(e_fe[d]));
      check($sformatf("d%0d_fwd_sel", d + 1), 32'(o_fwd[d]), 32'(e_fwd[d]));
      check($sformatf("d%0d_perf_stall", d + 1), o_ps[d], eps);
      check($sformatf("d%0d_perf_flush", d + 1), o_pf[d], epf);
    end
  endtask

  // Clock edge: move every in-flight instruction one stage down.
  task automatic advance();
    instr_t n;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!in_rst) begin
        for (int s = 0; s < 3; s++) pipe[d][s] = '0;
        m_stall[d] = 32'd0; m_flush[d] = 32'd0;
      end else begin
        m_stall[d] = m_stall[d] + 32'(e_sd[d]);
        m_flush[d] = m_flush[d] + 32'(in_br);
        n = '0;
        if (in_valid && !e_fe[d] && !e_sd[d]) begin
          n.valid = 1'b1; n.we = in_we; n.ld = in_ld; n.dest = in_dest;
          n.src = in_src; n.used = in_used;
        end
        pipe[d][2] = pipe[d][1];
        pipe[d][1] = pipe[d][0];
        pipe[d][0] = n;
      end
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [2:0] used, input logic [3:0] dst,
                        input logic we, input logic ld);
    in_valid = v; in_src = {4'd0, s1, s0}; in_used = used;
    in_dest = dst; in_we = we; in_ld = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop(); in_br = 1'b0;
    for (int k = 0; k < 4; k++) begin settle(); advance(); end
  endtask

  function automatic logic [3:0] rnd_reg();
    case ($urandom_range(0, 5))
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd3;
      3: return 4'd4;
      4: return 4'd0;
      default: return 4'd15;
    endcase
  endfunction

  logic [31:0] perf_exp5, perf_exp2;

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) pipe[d][s] = '0;
      m_stall[d] = 32'd0; m_flush[d] = 32'd0;
    end
    in_rst = 1'b0; in_br = 1'b0; nop();

    // reset state
    settle();
    check("rst_flush_d", 32'(if1.flush_d), 32'd1);
    check("rst_stall_f", 32'(if1.stall_f), 32'd0);
    advance(); settle(); advance();
    in_rst = 1'b1;
    settle();
    check("post_rst_all", {26'd0, if1.stall_f, if1.stall_d, if1.flush_d, if1.flush_e, if1.fwd_sel[1:0]}, 32'd0);
    advance();

    // ADD R1 ; ADD R2,R1,R3 back to back -> MEM forward
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0); settle(); advance();
    set_id(1'b1, 4'd1, 4'd3, 3'b011, 4'd2, 1'b1, 1'b0); settle(); advance();
    nop(); settle();
    check("fwd_mem_slot0", 32'(if1.fwd_sel[1:0]), 32'd2);
    check("fwd_mem_nostall", 32'(if1.stall_d), 32'd0);
    advance();
    // one NOP between -> WB forward
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0); settle(); advance();
    nop(); settle(); advance();
    set_id(1'b1, 4'd1, 4'd3, 3'b011, 4'd2, 1'b1, 1'b0); settle(); advance();
    nop(); settle();
    check("fwd_wb_slot0", 32'(if1.fwd_sel[1:0]), 32'd1);
    advance();
    drain();

    // LDR R4 ; ADD R5,R4,R6 -> 1 stall (LOAD_LAT=1), 2 stalls (LOAD_LAT=2)
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b1); settle(); advance();
    set_id(1'b1, 4'd4, 4'd6, 3'b011, 4'd5, 1'b1, 1'b0); settle();
    check("lu1_c1", {29'd0, if1.stall_f, if1.stall_d, if1.flush_e}, 32'd7);
    check("lu2_c1", {29'd0, if2.stall_f, if2.stall_d, if2.flush_e}, 32'd7);
    advance(); settle();
    check("lu1_c2_release", 32'(if1.stall_d), 32'd0);
    check("lu2_c2_stall", 32'(if2.stall_d), 32'd1);
    advance(); settle();
    check("lu1_fwd_wb", 32'(if1.fwd_sel[1:0]), 32'd1);
    check("lu2_c3_release", 32'(if2.stall_d), 32'd0);
    advance();
    drain();

    // taken branch during load-use stall
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b1); settle(); advance();
    set_id(1'b1, 4'd4, 4'd6, 3'b011, 4'd5, 1'b1, 1'b0); in_br = 1'b1; settle();
    check("br_over_lu", {28'd0, if1.stall_f, if1.stall_d, if1.flush_d, if1.flush_e}, 32'd3);
    advance(); in_br = 1'b0;
    drain();

    // MOV PC,R0 -> stall_f/flush_d for 3 cycles
    set_id(1'b1, 4'd0, 4'd0, 3'b001, 4'd15, 1'b1, 1'b0); settle();
    check("pcw_c1", {30'd0, if1.stall_f, if1.flush_d}, 32'd3);
    advance(); nop(); settle();
    check("pcw_c2", {30'd0, if1.stall_f, if1.flush_d}, 32'd3);
    advance(); settle();
    check("pcw_c3", {30'd0, if1.stall_f, if1.flush_d}, 32'd3);
    advance(); settle();
    check("pcw_released", {30'd0, if1.stall_f, if1.flush_d}, 32'd0);
    advance();
    drain();

    // read of R15 with pending R15 write in MEM -> no forwarding
    set_id(1'b1, 4'd0, 4'd0, 3'b001, 4'd15, 1'b1, 1'b0); settle(); advance();
    set_id(1'b1, 4'd15, 4'd0, 3'b001, 4'd2, 1'b1, 1'b0); settle(); advance();
    nop(); settle();
    check("pc_no_fwd", 32'(if1.fwd_sel[1:0]), 32'd0);
    advance();
    drain();

    // reset during a load-use stall
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b1); settle(); advance();
    set_id(1'b1, 4'd4, 4'd6, 3'b011, 4'd5, 1'b1, 1'b0); in_rst = 1'b0; settle();
    check("rst_kills_stall", {28'd0, if2.stall_f, if2.stall_d, if2.flush_d, if2.flush_e}, 32'd3);
    advance(); in_rst = 1'b1; settle();
    check("rst_tags_clear", {26'd0, if2.stall_f, if2.stall_d, if2.flush_d, if2.flush_e, if2.fwd_sel[1:0]}, 32'd0);
    advance();
    drain();

    // 5 load-use stalls then 2 branches, from a fresh reset
    in_rst = 1'b0; settle(); advance(); in_rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b1); settle(); advance();
      set_id(1'b1, 4'd4, 4'd6, 3'b011, 4'd5, 1'b1, 1'b0); settle(); advance();
      nop(); settle(); advance();
      settle(); advance();
    end
    in_br = 1'b1; settle(); advance(); settle(); advance(); in_br = 1'b0;
    settle();
`ifdef HAZARD_PERF_CNT_EN
    perf_exp5 = 32'd5; perf_exp2 = 32'd2;
`else
    perf_exp5 = 32'd0; perf_exp2 = 32'd0;
`endif
    check("perf_stall_5", ps1, perf_exp5);
    check("perf_flush_2", pf1, perf_exp2);
    check("perf2_stall_5", ps2, perf_exp5);
    advance();

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      in_rst   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_src   = {4'd0, rnd_reg(), rnd_reg()} | {rnd_reg(), 8'd0};
      in_used  = 3'($urandom_range(0, 7));
      in_dest  = rnd_reg();
      in_we    = ($urandom_range(0, 9) < 7);
      in_ld    = ($urandom_range(0, 9) < 3);
      in_br    = ($urandom_range(0, 9) == 0);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
